// File: rtl/seq_det_param.sv
// seq_det_param
// Runtime-configurable serial pattern detector with overlapping or
// non-overlapping detection, a saturating match counter and rejection of
// configurations with an out-of-range length.
//
// Ports
//   Clk          clock, all state changes on the rising edge
//   Rst          synchronous active-high reset, overrides every other input
//   B            serial data bit
//   Valid        B is sampled only while high
//   Cfg_Load     load Cfg_Pattern / Cfg_Len / Cfg_Overlap this cycle
//   Cfg_Pattern  pattern; bit Len-1 is received first, bit 0 last
//   Cfg_Len      pattern length, accepted when 1..MAX_LEN
//   Cfg_Overlap  1 = overlapping detection, 0 = non-overlapping
//   Clr_Cnt      clear the match counter
//   w            registered one-cycle match pulse
//   Match_Cnt    saturating match count
//   Cfg_Err      registered one-cycle pulse for a rejected configuration

module seq_det_param #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(8'b0000_0110),
    parameter int unsigned          DEF_LEN     = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 B,
    input  logic                 Valid,
    input  logic                 Cfg_Load,
    input  logic [MAX_LEN-1:0]   Cfg_Pattern,
    input  logic [4:0]           Cfg_Len,
    input  logic                 Cfg_Overlap,
    input  logic                 Clr_Cnt,
    output logic                 w,
    output logic [CNT_W-1:0]     Match_Cnt,
    output logic                 Cfg_Err
);

    // Length and fill share one width so they compare without extension.
    localparam int unsigned        LEN_W     = 5;
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic {
        S_FILL   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Registered state
    state_t                 state_q, state_d;
    logic [MAX_LEN-1:0]     hist_q,  hist_d;
    logic [LEN_W-1:0]       fill_q,  fill_d;
    logic [MAX_LEN-1:0]     pat_q,   pat_d;
    logic [LEN_W-1:0]       len_q,   len_d;
    logic                   ovl_q,   ovl_d;
    logic                   w_q,     w_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   err_q,   err_d;

    // Combinational helpers
    logic [MAX_LEN-1:0]     hist_shift;
    logic [LEN_W-1:0]       fill_inc;
    logic [MAX_LEN-1:0]     len_mask;
    logic                   cfg_ok;
    logic                   pat_eq;
    logic                   match;

    // History with the incoming bit appended, fill count saturating at MAX_LEN.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], B};
        fill_inc   = (fill_q >= MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    end

    // Select the low Len bits; pattern bits at or above Len never take part.
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // Compare the post-shift history against the active pattern.
    always_comb begin
        pat_eq = (((hist_shift ^ pat_q) & len_mask) == '0);
    end

    // A configuration is accepted only for 1 <= Cfg_Len <= MAX_LEN.
    always_comb begin
        cfg_ok = Cfg_Load && (Cfg_Len != '0) && (Cfg_Len <= MAX_LEN_L);
    end

    // State register: reset restores the default configuration.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEF_PATTERN;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= 1'b0;
            w_q     <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = 1'b0;
        match   = 1'b0;

        if (cfg_ok) begin
            // An accepted load wins over a coincident bit, which is dropped.
            pat_d   = Cfg_Pattern;
            len_d   = Cfg_Len;
            ovl_d   = Cfg_Overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else begin
            // A rejected load only flags the error; the bit is still taken.
            err_d = Cfg_Load;
            if (Valid) begin
                hist_d = hist_shift;
                fill_d = fill_inc;
                // ACTIVE already guarantees enough history; FILL checks the new count.
                match  = ((state_q == S_ACTIVE) || (fill_inc >= len_q)) && pat_eq;

                unique case (state_q)
                    S_FILL: begin
                        if (match && !ovl_q) begin
                            fill_d  = '0;
                            state_d = S_FILL;
                        end else if (fill_inc >= len_q) begin
                            state_d = S_ACTIVE;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                    S_ACTIVE: begin
                        // Non-overlapping mode never reuses bits of a match.
                        if (match && !ovl_q) begin
                            fill_d  = '0;
                            state_d = S_FILL;
                        end else begin
                            state_d = S_ACTIVE;
                        end
                    end
                    default: begin
                        state_d = S_FILL;
                    end
                endcase
            end
        end

        w_d = match;

        // Clear beats a coincident increment; the count never wraps.
        cnt_d = cnt_q;
        if (Clr_Cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign w         = w_q;
    assign Match_Cnt = cnt_q;
    assign Cfg_Err   = err_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.

module tb_seq_det_param;

    logic       Clk;
    logic       Rst;
    logic       B;
    logic       Valid;
    logic       Cfg_Load;
    logic [7:0] Cfg_Pattern;
    logic [4:0] Cfg_Len;
    logic       Cfg_Overlap;
    logic       Clr_Cnt;
    logic       w1, err1;
    logic [7:0] cnt1;
    logic       w2, err2;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    seq_det_param dut (
        .Clk(Clk), .Rst(Rst), .B(B), .Valid(Valid),
        .Cfg_Load(Cfg_Load), .Cfg_Pattern(Cfg_Pattern), .Cfg_Len(Cfg_Len),
        .Cfg_Overlap(Cfg_Overlap), .Clr_Cnt(Clr_Cnt),
        .w(w1), .Match_Cnt(cnt1), .Cfg_Err(err1)
    );

    seq_det_param #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .B(B), .Valid(Valid),
        .Cfg_Load(Cfg_Load), .Cfg_Pattern(Cfg_Pattern), .Cfg_Len(Cfg_Len),
        .Cfg_Overlap(Cfg_Overlap), .Clr_Cnt(Clr_Cnt),
        .w(w2), .Match_Cnt(cnt2), .Cfg_Err(err2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the sampling edge.
    task automatic tick(input logic v, input logic b, input logic ld, input logic clr);
        @(negedge Clk);
        Rst      = 1'b0;
        Valid    = v;
        B        = b;
        Cfg_Load = ld;
        Clr_Cnt  = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic bitw(input logic b, input logic exp_w, input string tag);
        tick(1'b1, b, 1'b0, 1'b0);
        chk(tag, 32'(w1), 32'(exp_w));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst      = 1'b1;
        Valid    = 1'b1;
        B        = 1'b0;
        Cfg_Load = 1'b0;
        Clr_Cnt  = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; B = 1'b0; Valid = 1'b0; Cfg_Load = 1'b0;
        Cfg_Pattern = 8'h06; Cfg_Len = 5'd3; Cfg_Overlap = 1'b0; Clr_Cnt = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_w", 32'(w1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_cnt", 32'(cnt1), 0);
        chk("rst_cnt_sat", 32'(cnt2), 0);

        // Default 110, two non-overlapping matches.
        bitw(1'b1, 1'b0, "d110_b1");
        bitw(1'b1, 1'b0, "d110_b2");
        bitw(1'b0, 1'b1, "d110_b3");
        bitw(1'b1, 1'b0, "d110_b4");
        bitw(1'b1, 1'b0, "d110_b5");
        bitw(1'b0, 1'b1, "d110_b6");
        chk("d110_cnt", 32'(cnt1), 2);
        chk("d110_cnt_sat", 32'(cnt2), 2);

        // Valid gaps inside the pattern.
        tick(1'b1, 1'b1, 1'b0, 1'b0); chk("gap_b1", 32'(w1), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0); chk("gap_g1", 32'(w1), 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0); chk("gap_b2", 32'(w1), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0); chk("gap_g2", 32'(w1), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0); chk("gap_b3", 32'(w1), 1);
        chk("gap_cnt", 32'(cnt1), 3);
        chk("gap_cnt_sat", 32'(cnt2), 3);

        // Rejected lengths 0 and 9; the second carries a bit that must count.
        Cfg_Pattern = 8'h06; Cfg_Len = 5'd0; Cfg_Overlap = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("len0_err", 32'(err1), 1);
        chk("len0_err_sat", 32'(err2), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("len0_err_clear", 32'(err1), 0);
        Cfg_Len = 5'd9;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("len9_err", 32'(err1), 1);
        chk("len9_w", 32'(w1), 0);
        bitw(1'b1, 1'b0, "len9_b2");
        bitw(1'b0, 1'b1, "len9_b3");
        chk("len9_err_clear", 32'(err1), 0);
        chk("len9_cnt", 32'(cnt1), 4);
        chk("len9_cnt_sat", 32'(cnt2), 3);

        // Fifth match: narrow counter stays saturated.
        bitw(1'b1, 1'b0, "sat_b1");
        bitw(1'b1, 1'b0, "sat_b2");
        bitw(1'b0, 1'b1, "sat_b3");
        chk("sat_cnt", 32'(cnt1), 5);
        chk("sat_cnt_sat", 32'(cnt2), 3);

        // Clear coincident with a match.
        bitw(1'b1, 1'b0, "clr_b1");
        bitw(1'b1, 1'b0, "clr_b2");
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_w", 32'(w1), 1);
        chk("clr_w_sat", 32'(w2), 1);
        chk("clr_cnt", 32'(cnt1), 0);
        chk("clr_cnt_sat", 32'(cnt2), 0);

        // 0101, Len 4, overlapping; upper pattern bits set but ignored.
        Cfg_Pattern = 8'b1111_0101; Cfg_Len = 5'd4; Cfg_Overlap = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ov_load_w", 32'(w1), 0);
        chk("ov_load_err", 32'(err1), 0);
        bitw(1'b0, 1'b0, "ov_b1");
        bitw(1'b1, 1'b0, "ov_b2");
        bitw(1'b0, 1'b0, "ov_b3");
        bitw(1'b1, 1'b1, "ov_b4");
        bitw(1'b0, 1'b0, "ov_b5");
        bitw(1'b1, 1'b1, "ov_b6");
        chk("ov_cnt", 32'(cnt1), 2);

        // Same pattern, non-overlapping.
        Cfg_Overlap = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("nov_load_w", 32'(w1), 0);
        bitw(1'b0, 1'b0, "nov_b1");
        bitw(1'b1, 1'b0, "nov_b2");
        bitw(1'b0, 1'b0, "nov_b3");
        bitw(1'b1, 1'b1, "nov_b4");
        bitw(1'b0, 1'b0, "nov_b5");
        bitw(1'b1, 1'b0, "nov_b6");
        chk("nov_cnt", 32'(cnt1), 3);

        // Load coincident with the completing bit of 110.
        Cfg_Pattern = 8'h06; Cfg_Len = 5'd3; Cfg_Overlap = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        bitw(1'b1, 1'b0, "ldc_b1");
        bitw(1'b1, 1'b0, "ldc_b2");
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ldc_w", 32'(w1), 0);
        bitw(1'b1, 1'b0, "ldc_after_b1");
        bitw(1'b0, 1'b0, "ldc_after_b2");
        chk("ldc_cnt", 32'(cnt1), 3);

        // Len 1, pattern bit 0 = 1.
        Cfg_Pattern = 8'hFF; Cfg_Len = 5'd1; Cfg_Overlap = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        bitw(1'b1, 1'b1, "len1_b1");
        bitw(1'b0, 1'b0, "len1_b2");
        bitw(1'b1, 1'b1, "len1_b3");
        bitw(1'b1, 1'b1, "len1_b4");
        chk("len1_cnt", 32'(cnt1), 6);

        // Reset mid-pattern, then defaults restored.
        do_reset();
        chk("rst2_cnt", 32'(cnt1), 0);
        bitw(1'b1, 1'b0, "rmid_b1");
        bitw(1'b1, 1'b0, "rmid_b2");
        do_reset();
        chk("rmid_rst_w", 32'(w1), 0);
        bitw(1'b0, 1'b0, "rmid_b3");
        bitw(1'b1, 1'b0, "rdef_b1");
        bitw(1'b1, 1'b0, "rdef_b2");
        bitw(1'b0, 1'b1, "rdef_b3");
        chk("rdef_cnt", 32'(cnt1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
